// File: rtl/lin_header_rx.sv
`default_nettype none
// ============================================================================
// Module   : lin_header_rx
// Purpose  : LIN responder header receiver (break, delimiter, sync, PID).
// Revision : 1.0 - initial release
// ============================================================================
module lin_header_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int BREAK_MIN    = 13,
    parameter int TIMEOUT_BITS = 14
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        sdi,
    output logic [5:0]  pid_out,
    output logic        pid_valid,
    output logic [33:0] frame_header_out,
    output logic        sync_err,
    output logic        parity_err,
    output logic        frame_err,
    output logic        timeout_err,
    output logic        busy
);
    localparam int c_BREAK_CYC = BREAK_MIN * CLKS_PER_BIT;
    localparam int c_TO_CYC    = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int c_TMR_MAX   = (c_TO_CYC > CLKS_PER_BIT) ? c_TO_CYC : CLKS_PER_BIT;
    localparam int LOW_W       = $clog2(c_BREAK_CYC + 1);
    localparam int TMR_W       = $clog2(c_TMR_MAX + 1);

    localparam logic [LOW_W-1:0] c_LOW_SAT   = LOW_W'(c_BREAK_CYC);
    localparam logic [TMR_W-1:0] c_BIT_END   = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0] c_TO_END    = TMR_W'(c_TO_CYC - 1);
    localparam logic [TMR_W-1:0] c_HALF_LOAD = TMR_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_BREAK      = 3'd1,
        S_DELIM      = 3'd2,
        S_WAIT_START = 3'd3,
        S_BYTE       = 3'd4,
        S_CHECK      = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync2_q, prev_q;
    logic [LOW_W-1:0]   low_cnt_q, low_cnt_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [3:0]         bit_idx_q, bit_idx_d;
    logic               byte_idx_q, byte_idx_d;
    logic [9:0]         frame_q, frame_d;
    logic [9:0]         sync_frame_q, sync_frame_d;
    logic [5:0]         pid_q, pid_d;
    logic [33:0]        hdr_q, hdr_d;
    logic               pid_valid_q, pid_valid_d;
    logic               sync_err_q, sync_err_d;
    logic               parity_err_q, parity_err_d;
    logic               frame_err_q, frame_err_d;
    logic               timeout_err_q, timeout_err_d;

    logic               w_s_sdi, w_fall, w_par_ok;
    logic [7:0]         w_data;

    assign w_s_sdi = sync2_q;
    assign w_fall  = prev_q & ~sync2_q;

    // Frame is held in line order (start at bit 9), so data bits come out reversed.
    always_comb begin
        w_data = '0;
        for (int i = 0; i < 8; i++) begin
            w_data[i] = frame_q[8-i];
        end
    end

    assign w_par_ok = (w_data[6] == (w_data[0] ^ w_data[1] ^ w_data[2] ^ w_data[4])) &&
                      (w_data[7] == ~(w_data[1] ^ w_data[3] ^ w_data[4] ^ w_data[5]));

    always_comb begin
        state_d       = state_q;
        low_cnt_d     = low_cnt_q;
        tmr_d         = tmr_q;
        bit_idx_d     = bit_idx_q;
        byte_idx_d    = byte_idx_q;
        frame_d       = frame_q;
        sync_frame_d  = sync_frame_q;
        pid_d         = pid_q;
        hdr_d         = hdr_q;
        pid_valid_d   = 1'b0;
        sync_err_d    = 1'b0;
        parity_err_d  = 1'b0;
        frame_err_d   = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The edge cycle itself is the first low cycle of the break.
                if (w_fall) begin
                    state_d   = S_BREAK;
                    low_cnt_d = LOW_W'(1);
                end
            end
            S_BREAK: begin
                if (!w_s_sdi) begin
                    if (low_cnt_q != c_LOW_SAT) begin
                        low_cnt_d = low_cnt_q + LOW_W'(1);
                    end
                end else if (low_cnt_q >= c_LOW_SAT) begin
                    state_d = S_DELIM;
                    tmr_d   = TMR_W'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DELIM: begin
                if (!w_s_sdi) begin
                    state_d     = S_IDLE;
                    frame_err_d = 1'b1;
                end else if (tmr_q == c_BIT_END) begin
                    state_d    = S_WAIT_START;
                    tmr_d      = '0;
                    byte_idx_d = 1'b0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_WAIT_START: begin
                if (w_fall) begin
                    state_d   = S_BYTE;
                    tmr_d     = c_HALF_LOAD;
                    bit_idx_d = '0;
                end else if (tmr_q == c_TO_END) begin
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_BYTE: begin
                if (tmr_q == '0) begin
                    frame_d   = {frame_q[8:0], w_s_sdi};
                    tmr_d     = c_BIT_END;
                    bit_idx_d = bit_idx_q + 4'd1;
                    if ((bit_idx_q == 4'd0) && w_s_sdi) begin
                        state_d     = S_IDLE;
                        frame_err_d = 1'b1;
                    end else if (bit_idx_q == 4'd9) begin
                        if (!w_s_sdi) begin
                            state_d     = S_IDLE;
                            frame_err_d = 1'b1;
                        end else begin
                            state_d = S_CHECK;
                        end
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if (!byte_idx_q) begin
                    if (w_data == 8'h55) begin
                        state_d      = S_WAIT_START;
                        byte_idx_d   = 1'b1;
                        tmr_d        = '0;
                        sync_frame_d = frame_q;
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end else if (w_par_ok) begin
                    pid_d       = w_data[5:0];
                    hdr_d       = {13'b0, 1'b1, sync_frame_q, frame_q};
                    pid_valid_d = 1'b1;
                end else begin
                    parity_err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            prev_q        <= 1'b1;
            state_q       <= S_IDLE;
            low_cnt_q     <= '0;
            tmr_q         <= '0;
            bit_idx_q     <= '0;
            byte_idx_q    <= 1'b0;
            frame_q       <= '0;
            sync_frame_q  <= '0;
            pid_q         <= '0;
            hdr_q         <= '0;
            pid_valid_q   <= 1'b0;
            sync_err_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            sync1_q       <= sdi;
            sync2_q       <= sync1_q;
            prev_q        <= sync2_q;
            state_q       <= state_d;
            low_cnt_q     <= low_cnt_d;
            tmr_q         <= tmr_d;
            bit_idx_q     <= bit_idx_d;
            byte_idx_q    <= byte_idx_d;
            frame_q       <= frame_d;
            sync_frame_q  <= sync_frame_d;
            pid_q         <= pid_d;
            hdr_q         <= hdr_d;
            pid_valid_q   <= pid_valid_d;
            sync_err_q    <= sync_err_d;
            parity_err_q  <= parity_err_d;
            frame_err_q   <= frame_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign pid_out          = pid_q;
    assign pid_valid        = pid_valid_q;
    assign frame_header_out = hdr_q;
    assign sync_err         = sync_err_q;
    assign parity_err       = parity_err_q;
    assign frame_err        = frame_err_q;
    assign timeout_err      = timeout_err_q;
    assign busy             = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lin_header_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_lin_header_rx
// Purpose  : Directed self-checking bench for lin_header_rx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lin_header_rx;
    localparam int CPB = 16;
    // Line edge to pid_valid: 2 sync flops + half bit + 9 bits + CHECK + output reg.
    localparam int c_PID_LAT = 156;
    localparam logic [33:0] c_HDR_3C = {13'b0, 1'b1, 10'h155, 10'h079};

    logic        clk, rst, sdi;
    logic [5:0]  pid_out;
    logic        pid_valid, sync_err, parity_err, frame_err, timeout_err, busy;
    logic [33:0] frame_header_out;

    int n_chk, n_pass, n_fail;
    int n_pid, n_sync, n_par, n_frame, n_to;
    int cyc, last_pid_cyc, pid_start_cyc;

    lin_header_rx #(
        .CLKS_PER_BIT (CPB),
        .BREAK_MIN    (13),
        .TIMEOUT_BITS (14)
    ) dut (
        .sys_clk          (clk),
        .rst              (rst),
        .sdi              (sdi),
        .pid_out          (pid_out),
        .pid_valid        (pid_valid),
        .frame_header_out (frame_header_out),
        .sync_err         (sync_err),
        .parity_err       (parity_err),
        .frame_err        (frame_err),
        .timeout_err      (timeout_err),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pid_valid) begin
            n_pid = n_pid + 1;
            last_pid_cyc = cyc;
        end
        if (sync_err)    n_sync  = n_sync + 1;
        if (parity_err)  n_par   = n_par + 1;
        if (frame_err)   n_frame = n_frame + 1;
        if (timeout_err) n_to    = n_to + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_pid = 0; n_sync = 0; n_par = 0; n_frame = 0; n_to = 0;
        last_pid_cyc = 0;
    endtask

    function automatic int n_err();
        return n_sync + n_par + n_frame + n_to;
    endfunction

    task automatic line(input logic v, input int cycles);
        sdi = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        line(1'b0, CPB);
        for (int i = 0; i < 8; i++) line(b[i], CPB);
        line(stop, CPB);
    endtask

    task automatic send_header(input int brk, input logic [7:0] sb,
                               input logic [7:0] pb, input logic pstop);
        line(1'b0, brk * CPB);
        line(1'b1, CPB);
        send_byte(sb, 1'b1);
        pid_start_cyc = cyc;
        send_byte(pb, pstop);
        line(1'b1, 3 * CPB);
    endtask

    initial begin
        logic [7:0] sb;
        n_chk = 0; n_pass = 0; n_fail = 0;
        pid_start_cyc = 0;
        clr();
        sdi = 1'b1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_pid_out", 64'(pid_out), 64'h0);
        chk("rst_header", 64'(frame_header_out), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_pulses", 64'({pid_valid, sync_err, parity_err, frame_err, timeout_err}), 64'h0);
        rst = 1'b0;
        line(1'b1, 2 * CPB);

        // Valid header, PID byte 0xC1 -> ID 0x01
        clr();
        send_header(13, 8'h55, 8'hC1, 1'b1);
        chk("A_pid_count", 64'(n_pid), 64'd1);
        chk("A_pid_out", 64'(pid_out), 64'h01);
        chk("A_errors", 64'(n_err()), 64'd0);
        chk("A_latency", 64'(last_pid_cyc - pid_start_cyc), 64'(c_PID_LAT));
        chk("A_busy_idle", 64'(busy), 64'h0);

        // Valid header, PID byte 0x3C, full header capture
        clr();
        send_header(13, 8'h55, 8'h3C, 1'b1);
        chk("B_pid_count", 64'(n_pid), 64'd1);
        chk("B_pid_out", 64'(pid_out), 64'h3C);
        chk("B_header", 64'(frame_header_out), 64'(c_HDR_3C));
        chk("B_errors", 64'(n_err()), 64'd0);

        // Break too short: ignored silently
        clr();
        send_header(10, 8'h55, 8'hC1, 1'b1);
        chk("short_brk_pid", 64'(n_pid), 64'd0);
        chk("short_brk_err", 64'(n_err()), 64'd0);
        chk("short_brk_busy", 64'(busy), 64'h0);
        chk("short_brk_pid_out", 64'(pid_out), 64'h3C);

        // Bad sync byte
        clr();
        send_header(13, 8'h54, 8'hC1, 1'b1);
        chk("sync_err_count", 64'(n_sync), 64'd1);
        chk("sync_err_others", 64'(n_pid + n_par + n_frame + n_to), 64'd0);

        // Bad P1 parity
        clr();
        send_header(13, 8'h55, 8'h41, 1'b1);
        chk("par_err_count", 64'(n_par), 64'd1);
        chk("par_err_others", 64'(n_pid + n_sync + n_frame + n_to), 64'd0);
        chk("par_err_pid_out", 64'(pid_out), 64'h3C);
        chk("par_err_header", 64'(frame_header_out), 64'(c_HDR_3C));

        // Line idle 15 bit times after the sync byte
        clr();
        line(1'b0, 13 * CPB);
        line(1'b1, CPB);
        send_byte(8'h55, 1'b1);
        line(1'b1, 15 * CPB);
        chk("timeout_count", 64'(n_to), 64'd1);
        chk("timeout_others", 64'(n_pid + n_sync + n_par + n_frame), 64'd0);

        // PID stop bit forced low
        clr();
        send_header(13, 8'h55, 8'hC1, 1'b0);
        chk("frame_err_count", 64'(n_frame), 64'd1);
        chk("frame_err_others", 64'(n_pid + n_sync + n_par + n_to), 64'd0);
        chk("frame_err_pid_out", 64'(pid_out), 64'h3C);

        // Reset in the middle of the sync byte, then a clean header
        clr();
        sb = 8'h55;
        line(1'b0, 13 * CPB);
        line(1'b1, CPB);
        line(1'b0, CPB);
        line(sb[0], CPB);
        line(sb[1], CPB);
        line(sb[2], 8);
        chk("mid_rst_busy_before", 64'(busy), 64'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'h0);
        chk("mid_rst_pid_out", 64'(pid_out), 64'h0);
        line(sb[2], 3);
        rst = 1'b0;
        line(sb[2], 5);
        for (int i = 3; i < 8; i++) line(sb[i], CPB);
        line(1'b1, CPB);
        send_byte(8'hC1, 1'b1);
        line(1'b1, 3 * CPB);
        chk("mid_rst_no_pulse", 64'(n_pid + n_err()), 64'd0);
        clr();
        send_header(13, 8'h55, 8'hC1, 1'b1);
        chk("post_rst_pid_count", 64'(n_pid), 64'd1);
        chk("post_rst_pid_out", 64'(pid_out), 64'h01);
        chk("post_rst_errors", 64'(n_err()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
